// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM duty decoder.
package pwm_pkg;

    typedef logic [7:0] duty_t;

    localparam int PWM_PERIOD_DEFAULT = 256;

    typedef enum logic {
        IDLE,
        MEASURE
    } dec_state_t;

endpackage

// File: rtl/pwm_in_cond.sv
// PWM input conditioning: 2-flop synchronizer, optional deglitch filter and rise detector.
// Build option: define PWM_DEGLITCH_EN to require 3 identical samples before the level changes.
module pwm_in_cond
    import pwm_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic pwm_i,
    output logic level_o,
    output logic rise_o
);

    logic s1_q;
    logic s2_q;
    logic prev_q;
    logic level;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= pwm_i;
            s2_q   <= s1_q;
            prev_q <= level;
        end
    end

`ifdef PWM_DEGLITCH_EN
    logic h1_q;
    logic h2_q;
    logic filt_q;

    // Level follows s2 only once the current and two previous samples agree.
    always_comb begin
        level = filt_q;
        if (s2_q && h1_q && h2_q) begin
            level = 1'b1;
        end else if (!s2_q && !h1_q && !h2_q) begin
            level = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h1_q   <= 1'b0;
            h2_q   <= 1'b0;
            filt_q <= 1'b0;
        end else begin
            h1_q   <= s2_q;
            h2_q   <= h1_q;
            filt_q <= level;
        end
    end
`else
    assign level = s2_q;
`endif

    assign level_o = level;
    assign rise_o  = level & ~prev_q;

endmodule

// File: rtl/pwm_duty_decoder.sv
// Recovers the duty value of a PWM waveform; one sample per period, static lines via timeout.
// Build option: PWM_DEGLITCH_EN enables the input deglitch filter in pwm_in_cond.
module pwm_duty_decoder
    import pwm_pkg::*;
#(
    parameter int PWM_PERIOD = PWM_PERIOD_DEFAULT,
    parameter int PERIOD_TOL = 2,
    parameter int TIMEOUT    = 512,
    parameter int DUTY_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty_out,
    output logic              duty_valid,
    output logic              locked,
    output logic              period_err
);

    localparam int CW       = $clog2(TIMEOUT + 1);
    localparam int PER_LO   = PWM_PERIOD - PERIOD_TOL;
    localparam int PER_HI   = PWM_PERIOD + PERIOD_TOL;
    localparam int DUTY_MAX = (1 << DUTY_W) - 1;

    logic              level;
    logic              rise;
    dec_state_t        state_q;
    logic [CW-1:0]     per_cnt_q;
    logic [CW-1:0]     per_cnt_d;
    logic [CW-1:0]     hi_cnt_q;
    logic [CW-1:0]     hi_cnt_d;
    logic              expire;
    logic              periodOk;
    logic [DUTY_W-1:0] hiSat;

    pwm_in_cond u_cond (
        .clk_i   (clk),
        .rst_i   (rst),
        .pwm_i   (pwm_in),
        .level_o (level),
        .rise_o  (rise)
    );

    // A rise always wins over an expiring timeout; expiry restarts the period count at 0.
    always_comb begin
        expire   = !rise && (int'(per_cnt_q) >= TIMEOUT - 1);
        periodOk = (int'(per_cnt_q) >= PER_LO) && (int'(per_cnt_q) <= PER_HI);
        hiSat    = (int'(hi_cnt_q) > DUTY_MAX) ? DUTY_W'(DUTY_MAX) : DUTY_W'(hi_cnt_q);
        per_cnt_d = per_cnt_q;
        hi_cnt_d  = hi_cnt_q;
        if (rise) begin
            per_cnt_d = CW'(1);
            hi_cnt_d  = {{(CW-1){1'b0}}, level};
        end else if (expire) begin
            per_cnt_d = '0;
            hi_cnt_d  = '0;
        end else begin
            if (int'(per_cnt_q) < TIMEOUT) begin
                per_cnt_d = per_cnt_q + CW'(1);
            end
            if (level && (int'(hi_cnt_q) < TIMEOUT)) begin
                hi_cnt_d = hi_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            per_cnt_q  <= '0;
            hi_cnt_q   <= '0;
            duty_out   <= '0;
            duty_valid <= 1'b0;
            locked     <= 1'b0;
            period_err <= 1'b0;
        end else begin
            per_cnt_q  <= per_cnt_d;
            hi_cnt_q   <= hi_cnt_d;
            duty_valid <= 1'b0;
            period_err <= 1'b0;
            if (rise) begin
                // The first rise after IDLE only opens a measurement window.
                if (state_q == MEASURE) begin
                    if (periodOk) begin
                        duty_out   <= hiSat;
                        duty_valid <= 1'b1;
                        locked     <= 1'b1;
                    end else begin
                        period_err <= 1'b1;
                        locked     <= 1'b0;
                    end
                end
                state_q <= MEASURE;
            end else if (expire) begin
                duty_out   <= level ? DUTY_W'(DUTY_MAX) : '0;
                duty_valid <= 1'b1;
                locked     <= 1'b0;
                state_q    <= IDLE;
            end
        end
    end

endmodule

// File: doc/pwm_duty_decoder.md
Name: pwm_duty_decoder

Overview:
Recovers the 8-bit duty value from a single PWM waveform of the form generated by the team's `pwm` block (256-cycle period, high for `duty` cycles).
Used to loop back `red_led`/`green_led`/`blue_led` for self-check, or to accept PWM control from an external board.
Measures high time between consecutive rising edges, validates the period, and reports one duty sample per period.
Static lines (0% / 100%) are resolved by timeout.

Parameters:
- PWM_PERIOD, 256, expected PWM period in clk cycles.
- PERIOD_TOL, 2, allowed ± deviation of the measured period from PWM_PERIOD.
- TIMEOUT, 512, cycles without a rising edge before the line is declared static.
- DUTY_W, 8, width of `duty_out`.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- pwm_in  in  1  asynchronous PWM input
- duty_out  out  DUTY_W  last decoded duty value
- duty_valid  out  1  one-cycle strobe, `duty_out` updated this cycle
- locked  out  1  at least one valid period measured since last loss of lock
- period_err  out  1  one-cycle strobe, measured period out of tolerance

Behaviour:
- Clock, reset and registers
  - Single clk domain; rst is synchronous and active-high.
  - Reset values: `duty_out`=0, `duty_valid`=0, `locked`=0, `period_err`=0; state=IDLE; all counters 0; synchronizer flops 0.
  - rst asserted at any point, including mid-high-phase, discards any measurement in progress.
- Input conditioning
  - `pwm_in` passes through a 2-flop synchronizer (s1→s2), then a `prev` flop.
  - rise = s2 & ~prev.
- Counters
  - `per_cnt` and `hi_cnt` are both $clog2(TIMEOUT+1) bits wide.
  - `per_cnt` increments every cycle and saturates at TIMEOUT.
  - `hi_cnt` increments on cycles where s2=1.
  - Both counters load 1/s2 on a rise cycle; the rise cycle itself counts.
- State machine
  - IDLE: wait for rise → MEASURE (counters loaded); no output.
  - MEASURE, on rise:
    - Previous period P = `per_cnt`, high time H = `hi_cnt`.
    - If |P − PWM_PERIOD| ≤ PERIOD_TOL: next cycle `duty_out` = min(H, 2^DUTY_W−1), `duty_valid`=1, `locked`=1.
    - Otherwise: next cycle `period_err`=1, `duty_valid`=0, `locked`=0, `duty_out` held.
    - In both cases stay in MEASURE with counters reloaded.
  - MEASURE or IDLE, `per_cnt` reaching TIMEOUT with no rise (static line):
    - Next cycle `duty_out` = s2 ? 2^DUTY_W−1 : 0, `duty_valid`=1, `locked`=0.
    - State → IDLE; `per_cnt` restarts at 0.
    - The timeout report therefore repeats every TIMEOUT cycles while the line stays static.
    - The IDLE timeout also runs out of reset.
- Arbitration
  - A rise on the same cycle as timeout expiry: the rise wins and no timeout report is issued.
  - `duty_valid` and `period_err` are never asserted together.
- Latency
  - `duty_valid` asserts 3 clk edges after the first edge that samples `pwm_in` high at the start of the next period.
- Expected first lock
  - The first rise after reset or IDLE produces no output.
  - The second rise yields the first sample, so `locked` rises ≤ 2·PWM_PERIOD+3 cycles after PWM starts.
- Mapping to the `pwm` block
  - `pwm` duty d (1..255) gives H=d and P=256, so `duty_out`=d.
  - d=0 is a constant low line and reports 0 via timeout.

Optional Feature:
- Macro: PWM_DEGLITCH_EN.
- Defined: a deglitch stage after s2 changes the filtered level only after 3 consecutive identical samples.
  - Pulses or gaps shorter than 3 cycles are ignored.
  - All latencies increase by 2 cycles.
  - Measured H and P are unchanged for clean input.
- Undefined: s2 feeds the edge detector directly.

Decomposition:
- Package `pwm_pkg`:
  - `duty_t` typedef (logic [7:0]).
  - PWM_PERIOD_DEFAULT constant (256).
  - `dec_state_t` enum {IDLE, MEASURE}.
- One natural sub-module: `pwm_in_cond`.
  - Contains the synchronizer, optional deglitch stage and rise detector.
  - Outputs: level, rise.

Test Plan:
- Steady duty 128 from `pwm` instance → no output on the first rise; `duty_out`=128 strobed once per 256 cycles thereafter; `locked`=1 after the second rise.
- Duty steps 255→1 → samples 255 then 1, each with `duty_valid`; no `period_err`.
- Line held low (duty 0) → after 512 cycles `duty_out`=0, `duty_valid`=1, `locked`=0; repeats every 512 cycles.
- Line held high → `duty_out`=255 every 512 cycles.
- Period 300, high 100 → `period_err` pulse each period; `duty_out` unchanged; `locked`=0.
- rst mid-high-phase → all outputs 0 the next cycle; the first sample after the second subsequent rise is correct. With PWM_DEGLITCH_EN, a 1-cycle glitch inside the high phase is ignored: `duty_out` stays 128.
